// File: rtl/sm_clk_pkg.sv
// Shared types and default parameter values for the clock-step controller.
package sm_clk_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StBurst
  } state_e;

  localparam int unsigned DefDivW      = 4;
  localparam int unsigned DefDebCycles = 16;
  localparam int unsigned DefBurstW    = 8;
  localparam int unsigned DefCntW      = 32;

endpackage

// File: rtl/sm_debounce.sv
// Two-flop synchronizer and level debouncer for the step key.
// Produces a one-cycle pulse that is aligned with the accepted 0->1 level change.
module sm_debounce
  import sm_clk_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DefDebCycles
) (
  input  logic clk,
  input  logic rst,
  input  logic in_raw,
  output logic out_level,
  output logic rise
);

  localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            rise_q, rise_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Run length counts consecutive cycles of disagreement; any agreeing cycle restarts it.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(DEB_CYCLES - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= in_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_level = level_q;
  assign rise      = rise_q;

endmodule

// File: rtl/sm_clk_step_ctrl.sv
// Clock-enable generator for single-stepping a core: continuous divided enables
// while run is high, or a burst of burst_len enables per debounced key press.
module sm_clk_step_ctrl
  import sm_clk_pkg::*;
#(
  parameter int unsigned DIV_W      = DefDivW,
  parameter int unsigned DEB_CYCLES = DefDebCycles,
  parameter int unsigned BURST_W    = DefBurstW,
  parameter int unsigned CNT_W      = DefCntW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               step_key,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [DIV_W-1:0]   div_sel,
  output logic               clk_en,
  output logic               busy,
  output logic [CNT_W-1:0]   step_cnt
);

  localparam int unsigned DivCntW = (1 << DIV_W) - 1;

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     div_sel_q, div_sel_d;
  logic [DivCntW-1:0]   div_cnt_q, div_cnt_d;
  logic [DivCntW-1:0]   div_mask;
  logic [BURST_W-1:0]   rem_q, rem_d;
  logic                 clk_en_q, clk_en_d;
  logic [CNT_W-1:0]     step_cnt_q, step_cnt_d;
  logic                 key_level;
  logic                 step_req;
  logic                 tick;

  sm_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .in_raw   (step_key),
    .out_level(key_level),
    .rise     (step_req)
  );

  assign div_mask = ~({DivCntW{1'b1}} << div_sel_q);
  assign tick     = (div_cnt_q == div_mask);

  always_comb begin
    state_d   = state_q;
    div_sel_d = div_sel_q;
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    rem_d     = rem_q;
    clk_en_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run) begin
          state_d = StRun;
        end else if (step_req) begin
          state_d = StBurst;
          rem_d   = (burst_len == '0) ? BURST_W'(1) : burst_len;
        end
      end
      StRun: begin
        if (!run) begin
          state_d = StIdle;
        end else begin
          clk_en_d = tick;
        end
      end
      StBurst: begin
        // run takes over immediately; the remaining burst is dropped.
        if (run) begin
          state_d = StRun;
          rem_d   = '0;
        end else if (rem_q == '0) begin
          state_d = StIdle;
        end else if (tick) begin
          clk_en_d = 1'b1;
          rem_d    = rem_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Divider restarts and picks up a new ratio only when the state changes.
    if (state_d != state_q) begin
      div_cnt_d = '0;
      div_sel_d = div_sel;
    end

    step_cnt_d = step_cnt_q + CNT_W'(clk_en_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      div_sel_q  <= '0;
      div_cnt_q  <= '0;
      rem_q      <= '0;
      clk_en_q   <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      div_sel_q  <= div_sel_d;
      div_cnt_q  <= div_cnt_d;
      rem_q      <= rem_d;
      clk_en_q   <= clk_en_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign clk_en   = clk_en_q;
  assign busy     = (state_q != StIdle);
  assign step_cnt = step_cnt_q;

  logic unused_level;
  assign unused_level = key_level;

endmodule

// File: tb/tb_sm_clk_step_ctrl.sv
// Scoreboard bench: stimulus pushes the expected cycle and count of each clk_en pulse,
// a negedge monitor pops and compares every pulse the DUT emits.
module tb_sm_clk_step_ctrl;

  localparam int unsigned DivW  = 4;
  localparam int unsigned Deb   = 4;
  localparam int unsigned BurstW = 8;
  localparam int unsigned CntW  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              run;
  logic              step_key;
  logic [BurstW-1:0] burst_len;
  logic [DivW-1:0]   div_sel;
  logic              clk_en;
  logic              busy;
  logic [CntW-1:0]   step_cnt;

  typedef struct {
    int              cyc;
    logic [CntW-1:0] cnt;
  } exp_t;

  exp_t            exp_q[$];
  int              cyc = 0;
  int              n_cmp = 0;
  int              n_err = 0;
  logic [CntW-1:0] sc = '0;

  sm_clk_step_ctrl #(
    .DIV_W     (DivW),
    .DEB_CYCLES(Deb),
    .BURST_W   (BurstW),
    .CNT_W     (CntW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .step_key (step_key),
    .burst_len(burst_len),
    .div_sel  (div_sel),
    .clk_en   (clk_en),
    .busy     (busy),
    .step_cnt (step_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every observed pulse must match the head of the queue.
  always @(negedge clk) begin
    if (clk_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: got pulse at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_step_cnt", int'(step_cnt), int'(e.cnt));
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int c);
    exp_t e;
    sc    = sc + 1'b1;
    e.cyc = c;
    e.cnt = sc;
    exp_q.push_back(e);
  endtask

  // dec = cycle in which the request is seen in IDLE.
  task automatic push_burst(input int dec, input int d, input int n);
    for (int k = 0; k < n; k++) push(dec + (1 << d) + 1 + k * (1 << d));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c;
    int d;
    rst = 1'b1; run = 1'b0; step_key = 1'b0; burst_len = '0; div_sel = '0;
    wait_cyc(3);
    chk("reset_clk_en", int'(clk_en), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_step_cnt", int'(step_cnt), 0);
    rst = 1'b0;
    wait_cyc(2);

    // Clean press: 3 pulses 4 apart, busy drops after the last.
    burst_len = 8'd3; div_sel = 4'd2;
    c = cyc; step_key = 1'b1;
    push_burst(c + 6, 2, 3);
    wait_until(c + 19);
    chk("busy_last_pulse", int'(busy), 1);
    wait_cyc(1);
    chk("busy_after_burst", int'(busy), 0);
    step_key = 1'b0;
    wait_cyc(12);
    chk("queue_empty_t1", exp_q.size(), 0);

    // Bouncing key, then stable high: exactly one burst.
    burst_len = 8'd2; div_sel = 4'd1;
    for (int i = 0; i < 20; i++) begin
      step_key = ((i / 2) % 2) == 0;
      wait_cyc(1);
    end
    c = cyc; step_key = 1'b1;
    push_burst(c + 6, 1, 2);
    wait_cyc(20);
    step_key = 1'b0;
    wait_cyc(10);
    chk("queue_empty_t2", exp_q.size(), 0);

    // Continuous run at full rate for 10 cycles.
    div_sel = 4'd0;
    c = cyc; run = 1'b1;
    for (int k = 2; k <= 10; k++) push(c + k);
    wait_cyc(10);
    run = 1'b0;
    wait_cyc(8);
    chk("queue_empty_t3", exp_q.size(), 0);
    chk("busy_after_run", int'(busy), 0);

    // burst_len 0 behaves as 1.
    burst_len = 8'd0; div_sel = 4'd1;
    c = cyc; step_key = 1'b1;
    push_burst(c + 6, 1, 1);
    wait_cyc(12);
    step_key = 1'b0;
    wait_cyc(10);

    // div_sel change mid-burst has no effect on spacing.
    burst_len = 8'd4; div_sel = 4'd1;
    c = cyc; step_key = 1'b1;
    push_burst(c + 6, 1, 4);
    wait_cyc(10);
    div_sel = 4'd3;
    wait_cyc(15);
    step_key = 1'b0;
    wait_cyc(10);
    chk("queue_empty_t4", exp_q.size(), 0);

    // run asserted after the 2nd of 5 burst pulses.
    burst_len = 8'd5; div_sel = 4'd2;
    c = cyc; step_key = 1'b1;
    d = c + 6;
    push_burst(d, 2, 2);
    push(d + 15); push(d + 19); push(d + 23);
    wait_until(d + 10);
    run = 1'b1;
    wait_until(d + 11);
    chk("busy_in_run", int'(busy), 1);
    wait_until(d + 23);
    run = 1'b0;
    wait_cyc(8);
    chk("busy_after_t5", int'(busy), 0);
    step_key = 1'b0;
    wait_cyc(10);
    chk("queue_empty_t5", exp_q.size(), 0);

    // Counter wrap: 17 pulses from reset leave step_cnt = 1 (CNT_W = 4).
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0; sc = '0;
    wait_cyc(1);
    chk("step_cnt_after_rst", int'(step_cnt), 0);
    div_sel = 4'd0;
    c = cyc; run = 1'b1;
    for (int k = 2; k <= 18; k++) push(c + k);
    wait_cyc(18);
    run = 1'b0;
    wait_cyc(3);
    chk("step_cnt_wrap", int'(step_cnt), 1);
    chk("queue_empty_t6", exp_q.size(), 0);

    // Reset mid-burst with key held through reset release.
    burst_len = 8'd5; div_sel = 4'd1;
    c = cyc; step_key = 1'b1;
    d = c + 6;
    push_burst(d, 1, 1);
    wait_until(d + 4);
    rst = 1'b1;
    wait_cyc(1);
    chk("midrst_clk_en", int'(clk_en), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_step_cnt", int'(step_cnt), 0);
    sc = '0;
    wait_cyc(1);
    rst = 1'b0;
    push_burst(d + 12, 1, 5);
    wait_cyc(25);
    step_key = 1'b0;
    wait_cyc(10);
    chk("queue_empty_t7", exp_q.size(), 0);
    chk("step_cnt_after_t7", int'(step_cnt), 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sm_clk_step_ctrl.md
SM_CLK_STEP_CTRL -- requirements
Module: sm_clk_step_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 4, width of div_sel; divide ratio is 2^div_sel.
REQ-002 SHALL have parameter DEB_CYCLES, default 16, number of stable cycles needed to accept a key level.
REQ-003 SHALL have parameter BURST_W, default 8, width of burst_len.
REQ-004 SHALL have parameter CNT_W, default 32, width of step_cnt.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 run  in  1  level; 1 = continuous divided enables.
REQ-008 step_key  in  1  raw asynchronous key, active-high (pressed = 1).
REQ-009 burst_len  in  BURST_W  enables per key press; 0 is treated as 1.
REQ-010 div_sel  in  DIV_W  log2 of the enable period in clk cycles.
REQ-011 clk_en  out  1  registered one-cycle enable for the downstream core.
REQ-012 busy  out  1  1 when state is not IDLE.
REQ-013 step_cnt  out  CNT_W  total clk_en pulses issued; wraps modulo 2^CNT_W.

Function
REQ-014 step_key SHALL pass through a 2-FF synchronizer, then a debouncer that changes its output only after the synchronized level differs from it for DEB_CYCLES consecutive cycles; any mismatch-free cycle resets the run length.
REQ-015 A step request SHALL be a one-cycle pulse on the debounced 0->1 edge; 1->0 edges SHALL produce no request.
REQ-016 The divider counter SHALL have width 2^DIV_W-1 bits, clear on every state entry, and assert tick when count == 2^div_sel_q - 1; div_sel_q SHALL be latched at state entry, and later div_sel changes SHALL take effect only at the next entry.
REQ-017 FSM states IDLE, RUN, BURST; clk_en SHALL be 0 in IDLE.
REQ-018 IDLE->RUN when run=1; IDLE->BURST on a step request with run=0; remaining SHALL be loaded with max(burst_len,1).
REQ-019 RUN SHALL assert clk_en the cycle after each tick and return to IDLE the cycle after run=0; step requests in RUN SHALL be discarded.
REQ-020 BURST SHALL assert clk_en the cycle after each tick and decrement remaining; it SHALL go to IDLE after the pulse that brings remaining to 0.
REQ-021 run=1 during BURST SHALL clear remaining and go to RUN next cycle, with no extra pulse in that cycle; step requests during BURST SHALL be discarded.
REQ-022 Latency: first clk_en SHALL occur exactly 2^div_sel_q + 1 cycles after the state-entry cycle (div_sel=0 -> every cycle after the first).
REQ-023 step_cnt SHALL increment in the same cycle clk_en is 1, wrapping from all-ones to 0.

Reset
REQ-024 On rst=1: state IDLE, clk_en 0, busy 0, step_cnt 0, divider 0, remaining 0, synchronizer and debounced level 0.
REQ-025 rst mid-burst SHALL abort the burst with no further clk_en; a key held through reset release SHALL produce exactly one request after 2+DEB_CYCLES cycles.

Structure
REQ-026 Package sm_clk_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-027 Debounce + synchronizer SHALL be a sub-module sm_debounce (params DEB_CYCLES; ports clk, rst, in_raw, out_level, rise).
REQ-028 Sequential logic SHALL have no latches and no derived or gated clocks; clk_en is the only timing output.

Verification (DEB_CYCLES=4)
REQ-029 run=0, burst_len=3, div_sel=2, clean key press -> exactly 3 clk_en pulses 4 cycles apart, step_cnt=3, busy falls after the last pulse.
REQ-030 Key bouncing 1/0 every 2 cycles for 20 cycles, then stable 1 -> exactly one burst, started 6 cycles after the stable 1.
REQ-031 run=1, div_sel=0 for 10 cycles -> 9 consecutive clk_en pulses (one latency cycle), then none after run=0.
REQ-032 burst_len=0, div_sel=1 -> single pulse; div_sel changed to 3 mid-burst (burst_len=4) -> spacing stays 2.
REQ-033 run asserted after 2nd of 5 burst pulses -> RUN entered, no pulse on the transition cycle, continuous pulses follow.
REQ-034 step_cnt preset path: CNT_W=4, 17 pulses -> step_cnt=1; rst mid-burst -> all outputs 0 next cycle.
